// File: rtl/alu_multicycle_pkg.sv
// Shared types for the multi-cycle ALU: operation codes, flag word and FSM states.
package alu_multicycle_pkg;

  typedef enum logic [3:0] {
    MOP_NOP = 4'd0,
    MOP_THR = 4'd1,
    MOP_ADD = 4'd2,
    MOP_ADC = 4'd3,
    MOP_SUB = 4'd4,
    MOP_SBC = 4'd5,
    MOP_SHL = 4'd6,
    MOP_SHR = 4'd7,
    MOP_ROL = 4'd8,
    MOP_ROR = 4'd9,
    MOP_AND = 4'd10,
    MOP_OR  = 4'd11,
    MOP_XOR = 4'd12,
    MOP_NOT = 4'd13,
    MOP_MUL = 4'd14
  } alu_mop_e;

  typedef struct packed {
    logic carry;
    logic zero;
    logic negative;
    logic overflow;
  } alu_mflag_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_FINISH = 2'd2
  } alu_mstate_e;

  function automatic logic is_shift_op(input alu_mop_e op);
    return (op == MOP_SHL) || (op == MOP_SHR) || (op == MOP_ROL) || (op == MOP_ROR);
  endfunction

endpackage

// File: rtl/alu_mul_step.sv
// One iteration of an unsigned shift-add multiplier: conditionally add the
// multiplicand into the high half, then shift the {hi,lo} pair right by one.
module alu_mul_step
  import alu_multicycle_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] mcand,
  input  logic [W-1:0] acc_hi,
  input  logic [W-1:0] acc_lo,
  output logic [W-1:0] acc_hi_next,
  output logic [W-1:0] acc_lo_next
);

  logic [W:0] sum;

  always_comb begin
    sum         = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : {(W+1){1'b0}});
    acc_hi_next = sum[W:1];
    acc_lo_next = {sum[0], acc_lo[W-1:1]};
  end

endmodule

// File: rtl/alu_multicycle.sv
// Clocked ALU with carry-chained arithmetic, iterative shifts/rotates and a
// shift-add multiplier behind a start/busy/done handshake.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter  int DATA_BUS_WIDTH = 8,
  localparam int SHAMT_WIDTH    = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  alu_mop_e                  op,
  input  logic [DATA_BUS_WIDTH-1:0] operand_a,
  input  logic [DATA_BUS_WIDTH-1:0] operand_b,
  input  logic [SHAMT_WIDTH-1:0]    shamt,
  output logic                      busy,
  output logic                      done,
  output logic [DATA_BUS_WIDTH-1:0] result,
  output logic [DATA_BUS_WIDTH-1:0] result_hi,
  output alu_mflag_t                flag
);

  localparam int W = DATA_BUS_WIDTH;

  // Handshake: start is taken only in IDLE (busy==0); busy stays high from the
  // next cycle through the single done cycle, and result/flag hold until the next done.
  alu_mstate_e            state_q, state_d;
  alu_mop_e               op_q, op_d;
  logic [W-1:0]           opa_q, opa_d;
  logic [W-1:0]           opb_q, opb_d;
  logic [W-1:0]           hi_q, hi_d;
  logic [W-1:0]           lo_q, lo_d;
  logic                   cin_q, cin_d;
  logic                   sh_nz_q, sh_nz_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic [W-1:0]           result_q, result_d;
  logic [W-1:0]           result_hi_q, result_hi_d;
  alu_mflag_t             flag_q, flag_d;

  logic [W-1:0] mul_hi, mul_lo;
  logic [W-1:0] sh_lo;
  logic         sh_out;
  logic [W:0]   sum, diff;
  logic         add_cin, sub_cin;
  logic         fin_upd, fin_c, fin_v;
  logic [W-1:0] fin_res, fin_hi;
  alu_mflag_t   fin_flag;

  alu_mul_step #(.W(W)) u_mul_step (
    .mcand       (opa_q),
    .acc_hi      (hi_q),
    .acc_lo      (lo_q),
    .acc_hi_next (mul_hi),
    .acc_lo_next (mul_lo)
  );

  always_comb begin : shift_step
    sh_lo  = lo_q;
    sh_out = 1'b0;
    case (op_q)
      MOP_SHL: begin
        sh_lo  = {lo_q[W-2:0], 1'b0};
        sh_out = lo_q[W-1];
      end
      MOP_SHR: begin
        sh_lo  = {1'b0, lo_q[W-1:1]};
        sh_out = lo_q[0];
      end
      MOP_ROL: sh_lo = {lo_q[W-2:0], lo_q[W-1]};
      MOP_ROR: sh_lo = {lo_q[0], lo_q[W-1:1]};
      default: ;
    endcase
  end

  // Result and flags for the operation, evaluated in the last EXEC cycle.
  always_comb begin : finish_calc
    add_cin = (op_q == MOP_ADC) & cin_q;
    sub_cin = (op_q == MOP_SBC) & cin_q;
    sum     = {1'b0, opa_q} + {1'b0, opb_q} + (W+1)'(add_cin);
    diff    = {1'b0, opa_q} - {1'b0, opb_q} - (W+1)'(sub_cin);
    fin_upd = 1'b1;
    fin_res = '0;
    fin_hi  = '0;
    fin_c   = 1'b0;
    fin_v   = 1'b0;
    case (op_q)
      MOP_THR: fin_res = opa_q;
      MOP_ADD, MOP_ADC: begin
        fin_res = sum[W-1:0];
        fin_c   = sum[W];
        fin_v   = (opa_q[W-1] == opb_q[W-1]) && (sum[W-1] != opa_q[W-1]);
      end
      MOP_SUB, MOP_SBC: begin
        fin_res = diff[W-1:0];
        fin_c   = diff[W];
        fin_v   = (opa_q[W-1] != opb_q[W-1]) && (diff[W-1] != opa_q[W-1]);
      end
      MOP_SHL, MOP_SHR, MOP_ROL, MOP_ROR: begin
        fin_res = sh_nz_q ? sh_lo : lo_q;
        fin_c   = sh_nz_q & sh_out;
      end
      MOP_AND: fin_res = opa_q & opb_q;
      MOP_OR:  fin_res = opa_q | opb_q;
      MOP_XOR: fin_res = opa_q ^ opb_q;
      MOP_NOT: fin_res = ~opa_q;
      MOP_MUL: begin
        fin_res = mul_lo;
        fin_hi  = mul_hi;
        fin_c   = |mul_hi;
      end
      default: fin_upd = 1'b0;
    endcase
    fin_flag.carry    = fin_c;
    fin_flag.zero     = ~|{fin_hi, fin_res};
    fin_flag.negative = (op_q == MOP_MUL) ? fin_hi[W-1] : fin_res[W-1];
    fin_flag.overflow = fin_v;
  end

  always_comb begin : fsm_next
    state_d     = state_q;
    op_d        = op_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    cin_d       = cin_q;
    sh_nz_d     = sh_nz_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flag_d      = flag_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_EXEC;
          op_d    = op;
          opa_d   = operand_a;
          opb_d   = operand_b;
          cin_d   = flag_q.carry;
          sh_nz_d = (shamt != '0);
          hi_d    = '0;
          lo_d    = operand_a;
          cnt_d   = '0;
          // Counter holds remaining EXEC cycles minus one.
          if (op == MOP_MUL) begin
            lo_d  = operand_b;
            cnt_d = SHAMT_WIDTH'(W - 1);
          end else if (is_shift_op(op) && (shamt != '0)) begin
            cnt_d = shamt - 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (op_q == MOP_MUL) begin
          hi_d = mul_hi;
          lo_d = mul_lo;
        end else if (is_shift_op(op_q) && sh_nz_q) begin
          lo_d = sh_lo;
        end
        if (cnt_q == '0) begin
          state_d = ST_FINISH;
          if (fin_upd) begin
            result_d    = fin_res;
            result_hi_d = fin_hi;
            flag_d      = fin_flag;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= MOP_NOP;
      opa_q       <= '0;
      opb_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cin_q       <= 1'b0;
      sh_nz_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      flag_q      <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cin_q       <= cin_d;
      sh_nz_q     <= sh_nz_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flag_q      <= flag_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag      = flag_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: transaction-level reference model with a per-cycle
// compare process, directed literal checks and randomized operations.
module tb_alu_multicycle;
  import alu_multicycle_pkg::*;

  localparam int W    = 8;
  localparam int SW   = $clog2(W);
  localparam int FULL = 1 << W;
  localparam int HALF = 1 << (W - 1);

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] res;
    alu_mflag_t   f;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  alu_mop_e      op;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic [SW-1:0] shamt;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic [W-1:0]  result_hi;
  alu_mflag_t    flag;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  alu_multicycle #(.DATA_BUS_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .shamt     (shamt),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .result_hi (result_hi),
    .flag      (flag)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model_op(input alu_mop_e o, input int a, input int b, input int sh,
                                    input exp_t cur);
    int   r, hi, s, sa, sb, cin;
    logic c, v;
    exp_t e;
    r   = 0;
    hi  = 0;
    c   = 1'b0;
    v   = 1'b0;
    cin = cur.f.carry ? 1 : 0;
    sa  = (a >= HALF) ? a - FULL : a;
    sb  = (b >= HALF) ? b - FULL : b;
    case (o)
      MOP_THR: r = a;
      MOP_ADD, MOP_ADC: begin
        if (o == MOP_ADD) cin = 0;
        s = a + b + cin;
        r = s % FULL;
        c = (s >= FULL);
        s = sa + sb + cin;
        v = (s >= HALF) || (s < -HALF);
      end
      MOP_SUB, MOP_SBC: begin
        if (o == MOP_SUB) cin = 0;
        s = a - b - cin;
        r = (s + FULL) % FULL;
        c = (s < 0);
        s = sa - sb - cin;
        v = (s >= HALF) || (s < -HALF);
      end
      MOP_SHL: begin
        r = (a << sh) % FULL;
        c = (sh > 0) && (((a >> (W - sh)) & 1) != 0);
      end
      MOP_SHR: begin
        r = a >> sh;
        c = (sh > 0) && (((a >> (sh - 1)) & 1) != 0);
      end
      MOP_ROL: r = ((a << sh) | (a >> (W - sh))) % FULL;
      MOP_ROR: r = ((a >> sh) | (a << (W - sh))) % FULL;
      MOP_AND: r = a & b;
      MOP_OR:  r = a | b;
      MOP_XOR: r = a ^ b;
      MOP_NOT: r = (FULL - 1) - a;
      MOP_MUL: begin
        s  = a * b;
        r  = s % FULL;
        hi = s / FULL;
        c  = (hi != 0);
      end
      default: return cur;
    endcase
    e.res        = W'(r);
    e.hi         = W'(hi);
    e.f.carry    = c;
    e.f.zero     = (r == 0) && (hi == 0);
    e.f.negative = (o == MOP_MUL) ? (hi >= HALF) : (r >= HALF);
    e.f.overflow = v;
    return e;
  endfunction

  function automatic int model_cycles(input alu_mop_e o, input int sh);
    if (o == MOP_MUL) return W;
    if (is_shift_op(o)) return (sh == 0) ? 1 : sh;
    return 1;
  endfunction

  // m_rem: cycles left until the model's op leaves its done cycle (0 = idle).
  exp_t         exp_q[$];
  int           m_rem = 0;
  logic [W-1:0] m_res = '0;
  logic [W-1:0] m_hi  = '0;
  alu_mflag_t   m_flag = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_res  <= '0;
      m_hi   <= '0;
      m_flag <= '0;
      exp_q.delete();
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) {m_hi, m_res, m_flag} <= exp_q.pop_front();
    end else if (start) begin
      exp_q.push_back(model_op(op, int'(operand_a), int'(operand_b), int'(shamt),
                               exp_t'({m_hi, m_res, m_flag})));
      m_rem <= model_cycles(op, int'(shamt)) + 1;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",      64'(busy),      64'(m_rem != 0));
      check("done",      64'(done),      64'(m_rem == 1));
      check("result",    64'(result),    64'(m_res));
      check("result_hi", 64'(result_hi), 64'(m_hi));
      check("flag",      64'(flag),      64'(m_flag));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input alu_mop_e o, input int a, input int b, input int sh, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    op        = o;
    operand_a = W'(a);
    operand_b = W'(b);
    shamt     = SW'(sh);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done && lat < 64);
    if (!done) check("done_timeout", 64'(lat), 64'(0));
  endtask

  task automatic expect_out(input string name, input int res, input int hi, input logic [3:0] flg);
    check({name, "_result"},    64'(result),    64'(res));
    check({name, "_result_hi"}, 64'(result_hi), 64'(hi));
    check({name, "_flag"},      64'(flag),      64'(flg));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int n_done;
    int cyc;
    rst_n     = 1'b0;
    start     = 1'b0;
    op        = MOP_NOP;
    operand_a = '0;
    operand_b = '0;
    shamt     = '0;
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'(0));
    expect_out("reset", 0, 0, 4'b0000);

    // add, then add-with-carry consuming the stored carry
    issue(MOP_ADD, 'hF0, 'h20, 0, lat);
    check("add_latency", 64'(lat), 64'(2));
    expect_out("add", 'h10, 0, 4'b1000);
    issue(MOP_ADC, 'h00, 'h00, 0, lat);
    check("adc_latency", 64'(lat), 64'(2));
    expect_out("adc", 'h01, 0, 4'b0000);

    issue(MOP_SUB, 'h80, 'h01, 0, lat);
    expect_out("sub", 'h7F, 0, 4'b0001);
    issue(MOP_SBC, 'h00, 'h00, 0, lat);
    expect_out("sbc", 'h00, 0, 4'b0100);

    issue(MOP_SHL, 'h81, 0, 3, lat);
    check("shl_latency", 64'(lat), 64'(4));
    expect_out("shl", 'h08, 0, 4'b0000);
    issue(MOP_SHR, 'h05, 0, 1, lat);
    expect_out("shr", 'h02, 0, 4'b1000);
    issue(MOP_ROR, 'h01, 0, 0, lat);
    check("ror0_latency", 64'(lat), 64'(2));
    expect_out("ror0", 'h01, 0, 4'b0000);

    issue(MOP_MUL, 'hFF, 'hFF, 0, lat);
    check("mul_latency", 64'(lat), 64'(9));
    expect_out("mul_ff", 'h01, 'hFE, 4'b1010);
    issue(MOP_MUL, 'h00, 'h37, 0, lat);
    expect_out("mul_zero", 'h00, 'h00, 4'b0100);

    // start held high through a whole MUL: exactly one operation runs
    @(negedge clk);
    op        = MOP_MUL;
    operand_a = 8'hFF;
    operand_b = 8'hFF;
    shamt     = '0;
    start     = 1'b1;
    n_done    = 0;
    cyc       = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (done) n_done++;
    end while (!done && cyc < 64);
    start = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("hold_start_dones", 64'(n_done), 64'(1));
    check("hold_start_latency", 64'(cyc), 64'(9));

    issue(MOP_NOP, 'h12, 'h34, 0, lat);
    check("nop_latency", 64'(lat), 64'(2));
    expect_out("nop", 'h01, 'hFE, 4'b1010);
    issue(alu_mop_e'(4'hF), 'h00, 'h00, 0, lat);
    expect_out("undef_op", 'h01, 'hFE, 4'b1010);

    // reset in the fourth EXEC cycle of a MUL
    @(negedge clk);
    op        = MOP_MUL;
    operand_a = 8'hFF;
    operand_b = 8'hFF;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    expect_out("abort", 0, 0, 4'b0000);
    issue(MOP_ADD, 'h01, 'h01, 0, lat);
    expect_out("post_abort_add", 'h02, 0, 4'b0000);

    for (int i = 0; i < 120; i++) begin
      issue(alu_mop_e'($urandom_range(0, 15)), $urandom_range(0, FULL - 1),
            $urandom_range(0, FULL - 1), $urandom_range(0, (1 << SW) - 1), lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
